stream_epoch_ctrl: RTL and testbench
====================================

STREAM_EPOCH_CTRL -- requirements
Module: stream_epoch_ctrl

Interface
REQ-001 SHALL have parameter LEN, default 1024: bitstream epoch length in cycles; power of two, at least 2.
REQ-002 SHALL have parameter WARMUP, default 4: cycles discarded for downstream network latency; 0 is legal.
REQ-003 SHALL have derived localparams IW = $clog2(LEN) and CW = IW+1.
REQ-004 SHALL have port clk, input, 1 bit: clock.
REQ-005 SHALL have port n_rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port start, input, 1 bit: request one epoch.
REQ-007 SHALL have port abort, input, 1 bit: cancel the running epoch.
REQ-008 SHALL have port y_in, input, 1 bit: result bitstream from the network.
REQ-009 SHALL have port gen_clr, output, 1 bit: synchronous clear to the constant generators and network.
REQ-010 SHALL have port gen_en, output, 1 bit: advance enable for the generators.
REQ-011 SHALL have port idx, output, IW bits: shared stream index for the constant generators.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port res_valid, output, 1 bit: result available.
REQ-014 SHALL have port res_ready, input, 1 bit: consumer accepts the result.
REQ-015 SHALL have port res_count, output, CW bits: number of ones in y_in over one epoch.

Function
REQ-016 SHALL implement the FSM states IDLE, CLEAR, WARM, RUN and DONE; all outputs SHALL be registered or decoded from the state only.
REQ-017 IDLE->CLEAR SHALL occur on start=1 and abort=0; with start and abort both high in IDLE, the FSM SHALL stay in IDLE.
REQ-018 CLEAR SHALL last 1 cycle with gen_clr=1, gen_en=0, idx<=0 and count<=0; it SHALL then go to WARM, or directly to RUN if WARMUP=0.
REQ-019 WARM SHALL last exactly WARMUP cycles with gen_en=1; y_in SHALL be ignored.
REQ-020 RUN SHALL last exactly LEN cycles with gen_en=1; each cycle count <= count + y_in.
REQ-021 RUN->DONE SHALL occur after the LEN-th sample; the final sample SHALL be included in count; res_count range is 0..LEN, so no overflow is possible at width CW.
REQ-022 idx SHALL increment by 1 modulo LEN on every cycle with gen_en=1, wrap LEN-1->0, and hold otherwise.
REQ-023 DONE SHALL drive res_valid=1 and gen_en=0, and hold res_count stable until res_valid&&res_ready; it SHALL then go to IDLE on the next cycle.
REQ-024 res_valid SHALL first rise exactly 1+WARMUP+LEN cycles after the clock edge that samples start.
REQ-025 start SHALL be ignored in every state other than IDLE, including the DONE handshake cycle.
REQ-026 abort=1 in CLEAR, WARM or RUN SHALL return the FSM to IDLE on the next edge, clear count, and produce no res_valid.
REQ-027 abort SHALL be ignored in IDLE and DONE.
REQ-028 res_count SHALL read 0 whenever res_valid=0.

Reset
REQ-029 While n_rst=0, the state SHALL be IDLE and idx, count, gen_clr, gen_en, busy and res_valid SHALL all be 0.
REQ-030 Reset asserted mid-epoch SHALL discard the epoch; the first edge after release SHALL be evaluated in IDLE.

Structure
REQ-031 Package stream_pkg SHALL hold the state enum typedef (epoch_state_t) and the LEN default constant shared with the generators.
REQ-032 The ones accumulator SHALL be sub-module stream_counter, with clear, enable, bit in and CW-bit count out.
REQ-033 idx SHALL replace the per-generator free-running counters; each generator SHALL add its own OFFSET modulo LEN.

Verification (LEN=1024, WARMUP=4)
REQ-034 y_in=1 constantly, start pulse -> res_valid 1029 cycles later with res_count=1024.
REQ-035 y_in=0 constantly -> res_count=0; idx observed 1023->0 wrap during RUN.
REQ-036 y_in = 1 on every 4th RUN cycle, WARM cycles driven with 1 -> res_count=256, proving WARM samples are excluded.
REQ-037 abort at RUN sample 500 -> IDLE next cycle, no res_valid; a following epoch with y_in=1 gives 1024.
REQ-038 res_ready held 0 for 10 cycles in DONE, with start pulsed -> res_valid and res_count stable, and start ignored.
REQ-039 n_rst pulsed mid-RUN -> all outputs 0 immediately; the next start gives a full, correct epoch.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared definitions for the stochastic stream epoch controller and its constant generators.
// Generators derive their stream position from the controller's shared index.
package stream_pkg;

  localparam int STREAM_LEN = 1024;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WARM,
    RUN,
    DONE
  } epoch_state_t;

  // A generator's stream position is the shared index plus its own offset, modulo the epoch length.
  function automatic int unsigned gen_index(input int unsigned idxIn, input int unsigned offset,
                                            input int unsigned len);
    return (idxIn + offset) % len;
  endfunction

endpackage

// File: rtl/stream_counter.sv
// Ones accumulator for the result bitstream.
// Clear has priority over enable.
module stream_counter #(
  parameter int CW = 11
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic          i_bit,
  output logic [CW-1:0] o_count
);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CW'(i_bit);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/stream_epoch_ctrl.sv
// Epoch sequencer for a stochastic bitstream network.
// Flow: clear generators, discard warm-up cycles, count ones for LEN cycles, then hold the result.
module stream_epoch_ctrl
  import stream_pkg::*;
#(
  parameter int LEN = STREAM_LEN,
  parameter int WARMUP = 4,
  localparam int IW = $clog2(LEN),
  localparam int CW = IW + 1
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          start,
  input  logic          abort,
  input  logic          y_in,
  output logic          gen_clr,
  output logic          gen_en,
  output logic [IW-1:0] idx,
  output logic          busy,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [CW-1:0] res_count
);

  localparam int MAXP = (LEN > WARMUP) ? LEN : WARMUP;
  localparam int PW = $clog2(MAXP + 1);
  localparam logic [PW-1:0] WARM_LAST = PW'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [PW-1:0] RUN_LAST = PW'(LEN - 1);

  epoch_state_t  r_state;
  epoch_state_t  w_next;
  logic [PW-1:0] r_phase;
  logic [IW-1:0] r_idx;
  logic          w_active;
  logic          w_clr;
  logic [CW-1:0] w_count;

  assign w_active = (r_state == CLEAR) || (r_state == WARM) || (r_state == RUN);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start && !abort) w_next = CLEAR;
      end
      CLEAR: begin
        if (abort) w_next = IDLE;
        else if (WARMUP == 0) w_next = RUN;
        else w_next = WARM;
      end
      WARM: begin
        if (abort) w_next = IDLE;
        else if (r_phase == WARM_LAST) w_next = RUN;
      end
      RUN: begin
        if (abort) w_next = IDLE;
        else if (r_phase == RUN_LAST) w_next = DONE;
      end
      DONE: begin
        if (res_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Cycles spent in the current WARM or RUN phase; restarts on every state change.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_phase <= '0;
    end else if (w_next != r_state) begin
      r_phase <= '0;
    end else if ((r_state == WARM) || (r_state == RUN)) begin
      r_phase <= r_phase + 1'b1;
    end else begin
      r_phase <= '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_idx <= '0;
    end else if (r_state == CLEAR) begin
      r_idx <= '0;
    end else if (gen_en) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  assign w_clr = (r_state == CLEAR) || (abort && w_active) || ((r_state == DONE) && res_ready);

  stream_counter #(
    .CW(CW)
  ) u_counter (
    .clk    (clk),
    .n_rst  (n_rst),
    .i_clr  (w_clr),
    .i_en   (r_state == RUN),
    .i_bit  (y_in),
    .o_count(w_count)
  );

  assign gen_clr   = (r_state == CLEAR);
  assign gen_en    = (r_state == WARM) || (r_state == RUN);
  assign busy      = (r_state != IDLE);
  assign res_valid = (r_state == DONE);
  assign res_count = res_valid ? w_count : '0;
  assign idx       = r_idx;

endmodule

// File: tb/tb_stream_epoch_ctrl.sv
// Self-checking bench for stream_epoch_ctrl: table-driven epoch patterns, random epochs
// against a window-sum reference, plus abort, handshake and reset corner sequences.
module tb_stream_epoch_ctrl;

  localparam int LEN = 1024;
  localparam int WARMUP = 4;
  localparam int IW = 10;
  localparam int CW = 11;
  // Edge index (counting the start-sampling edge as 0) of the first and last counted sample.
  localparam int RUN0 = 2 + WARMUP;
  localparam int LAT = 1 + WARMUP + LEN;

  logic          clk;
  logic          n_rst;
  logic          start;
  logic          abort;
  logic          y_in;
  logic          gen_clr;
  logic          gen_en;
  logic [IW-1:0] idx;
  logic          busy;
  logic          res_valid;
  logic          res_ready;
  logic [CW-1:0] res_count;

  int testsRun = 0;
  int testsFailed = 0;
  bit yv[0:2047];

  typedef struct {
    string name;
    int    mode;
    bit    warmVal;
    int    expCount;
  } vec_t;

  vec_t vecs[6];

  stream_epoch_ctrl #(
    .LEN(LEN),
    .WARMUP(WARMUP)
  ) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .start    (start),
    .abort    (abort),
    .y_in     (y_in),
    .gen_clr  (gen_clr),
    .gen_en   (gen_en),
    .idx      (idx),
    .busy     (busy),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_count(res_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream values per edge index; everything outside the RUN window is driven with warmVal.
  task automatic fillPattern(input int mode, input bit warmVal);
    for (int k = 0; k < 2048; k++) begin
      int r;
      r = k - RUN0;
      if (r >= 0 && r < LEN) begin
        case (mode)
          0: yv[k] = 1'b1;
          1: yv[k] = 1'b0;
          2: yv[k] = (r % 4 == 0);
          3: yv[k] = (r == LEN - 1);
          4: yv[k] = (r == 0);
          5: yv[k] = (r % 2 == 1);
          default: yv[k] = 1'($urandom_range(0, 1));
        endcase
      end else if (mode == 6) begin
        yv[k] = 1'($urandom_range(0, 1));
      end else begin
        yv[k] = warmVal;
      end
    end
  endtask

  function automatic int modelCount();
    int sum;
    sum = 0;
    for (int k = RUN0; k < RUN0 + LEN; k++) sum += int'(yv[k]);
    return sum;
  endfunction

  // Launch one epoch and follow it until res_valid, checking the per-cycle outputs on the way.
  task automatic applyStimulus(input string tag, input int expCount);
    int validAt, idxErr, flagErr, zeroErr, sawWrap, prevIdx;
    validAt = -1; idxErr = 0; flagErr = 0; zeroErr = 0; sawWrap = 0; prevIdx = -1;
    start = 1'b1; abort = 1'b0; res_ready = 1'b0; y_in = yv[0];
    tick();
    start = 1'b0;
    checkOutput({tag, ".clearFlags"}, int'({gen_clr, gen_en, busy, res_valid}), 'b1010);
    for (int k = 1; k <= LAT + 16 && validAt < 0; k++) begin
      y_in = yv[k];
      tick();
      if (res_valid) begin
        validAt = k;
      end else begin
        if (int'(idx) != (k - 1) % LEN) idxErr++;
        if (gen_en != (k <= WARMUP + LEN) || gen_clr != 1'b0 || busy != 1'b1) flagErr++;
        if (res_count != '0) zeroErr++;
        if (prevIdx == LEN - 1 && idx == '0) sawWrap++;
        prevIdx = int'(idx);
      end
    end
    checkOutput({tag, ".latency"}, validAt, LAT);
    checkOutput({tag, ".count"}, int'(res_count), expCount);
    checkOutput({tag, ".idxSeq"}, idxErr, 0);
    checkOutput({tag, ".runFlags"}, flagErr, 0);
    checkOutput({tag, ".countMasked"}, zeroErr, 0);
    checkOutput({tag, ".idxWrap"}, sawWrap, 1);
    checkOutput({tag, ".doneFlags"}, int'({gen_clr, gen_en, busy, res_valid}), 'b0011);
    checkOutput({tag, ".doneIdx"}, int'(idx), WARMUP % LEN);
  endtask

  // Hold DONE with ready low while poking start/abort, then complete the handshake with start high.
  task automatic finishDone(input string tag, input int expCount, input int hold);
    int stableErr;
    stableErr = 0;
    res_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      start = (i == 2);
      abort = (i == 5);
      y_in = 1'b1;
      tick();
      if (!res_valid || int'(res_count) != expCount || !busy) stableErr++;
    end
    start = 1'b1; abort = 1'b0; res_ready = 1'b1;
    tick();
    start = 1'b0; res_ready = 1'b0;
    checkOutput({tag, ".holdStable"}, stableErr, 0);
    checkOutput({tag, ".released"}, int'({busy, res_valid, res_count}), 0);
    tick();
    checkOutput({tag, ".startIgnored"}, int'(busy), 0);
  endtask

  initial begin
    vecs[0] = '{"ones", 0, 1'b1, 1024};
    vecs[1] = '{"zeros", 1, 1'b0, 0};
    vecs[2] = '{"every4", 2, 1'b1, 256};
    vecs[3] = '{"lastOnly", 3, 1'b1, 1};
    vecs[4] = '{"firstOnly", 4, 1'b1, 1};
    vecs[5] = '{"oddOnly", 5, 1'b0, 512};

    n_rst = 1'b0; start = 1'b0; abort = 1'b0; y_in = 1'b0; res_ready = 1'b0;
    #22;
    checkOutput("resetState", int'({gen_clr, gen_en, busy, res_valid, idx, res_count}), 0);
    #3 n_rst = 1'b1;
    tick();

    // start and abort together in IDLE must be ignored.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    checkOutput("startAbortIdle", int'(busy), 0);

    for (int i = 0; i < 6; i++) begin
      fillPattern(vecs[i].mode, vecs[i].warmVal);
      applyStimulus(vecs[i].name, vecs[i].expCount);
      finishDone(vecs[i].name, vecs[i].expCount, (i == 0) ? 10 : 1);
    end

    // Abort during CLEAR and during WARM.
    start = 1'b1;
    tick();
    start = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abortClear", int'({busy, gen_en, gen_clr, res_valid}), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checkOutput("inWarm", int'({gen_clr, gen_en, busy}), 'b011);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abortWarm", int'({busy, gen_en, res_valid}), 0);

    // Abort at RUN sample 500, then a clean all-ones epoch.
    begin
      int seenValid;
      seenValid = 0;
      start = 1'b1; y_in = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k < RUN0 + 500; k++) tick();
      checkOutput("preAbortRun", int'({gen_en, busy, res_valid}), 'b110);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checkOutput("abortRun", int'({busy, gen_en, res_valid, res_count}), 0);
      for (int k = 0; k < 20; k++) begin
        tick();
        if (res_valid || busy) seenValid++;
      end
      checkOutput("abortNoValid", seenValid, 0);
    end
    fillPattern(0, 1'b1);
    applyStimulus("afterAbort", 1024);
    finishDone("afterAbort", 1024, 2);

    // Asynchronous reset in the middle of RUN.
    start = 1'b1; y_in = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < RUN0 + 300; k++) tick();
    #2 n_rst = 1'b0;
    #1;
    checkOutput("asyncReset", int'({gen_clr, gen_en, busy, res_valid, idx, res_count}), 0);
    tick();
    tick();
    checkOutput("heldReset", int'({gen_clr, gen_en, busy, res_valid, idx, res_count}), 0);
    #3 n_rst = 1'b1;
    tick();
    checkOutput("postReset", int'(busy), 0);
    fillPattern(0, 1'b0);
    applyStimulus("afterReset", 1024);
    finishDone("afterReset", 1024, 1);

    // Random streams against the window-sum reference.
    for (int r = 0; r < 4; r++) begin
      int expCount;
      fillPattern(6, 1'b0);
      expCount = modelCount();
      applyStimulus($sformatf("rand%0d", r), expCount);
      finishDone($sformatf("rand%0d", r), expCount, int'($urandom_range(0, 6)));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule
